// File: rtl/stack_ctrl.sv
// stack_ctrl: two-requester arbiter/sequencer for the hardware stack.
// Ports: clk, rst (async, active-low); req_valid/req_op/req_data0/1 and
//   req_ready form the request side; stk_* drive the stack; rd_valid,
//   rd_id, rd_data return pop data; level/full/empty report occupancy;
//   ovf_err/unf_err are sticky and cleared by err_clr.
// Build option: STACK_CTRL_FIXED_PRIO_EN selects fixed priority
//   (requester 0 wins) instead of round-robin arbitration.
module stack_ctrl #(
  parameter int NADDR = 7,
  parameter int DEPTH = 2,
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_op,
  input  logic [NBITS-1:0] req_data0,
  input  logic [NBITS-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic             stk_rst,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [NBITS-1:0] stk_in,
  input  logic [NBITS-1:0] stk_out,
  output logic             rd_valid,
  output logic             rd_id,
  output logic [NBITS-1:0] rd_data,
  output logic [NADDR-1:0] level,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             unf_err,
  input  logic             err_clr
);

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam logic [NADDR-1:0] LMAX = NADDR'(DEPTH);
  localparam logic [NADDR-1:0] ONE  = NADDR'(1);

  state_t state;
  state_t state_nx;

  logic [1:0] elig;
  logic [1:0] gnt_raw;
  logic [1:0] gnt;
  logic       any;
  logic       gid;
  logic       gop;
  logic       psh;
  logic       pop;
  logic       do_push;
  logic       do_pop;

`ifndef STACK_CTRL_FIXED_PRIO_EN
  logic       rr;
`endif

  assign stk_rst = ~rst;
  assign full    = (level == LMAX);
  assign empty   = (level == '0);

  // Pops wait out the top-of-stack lag that follows a push.
  always_comb begin
    elig = req_valid;
    if (state == SETTLE) begin
      elig = req_valid & req_op;
    end
  end

`ifdef STACK_CTRL_FIXED_PRIO_EN
  always_comb begin
    gnt_raw    = 2'b00;
    gnt_raw[0] = elig[0];
    gnt_raw[1] = elig[1] & ~elig[0];
  end
`else
  always_comb begin
    gnt_raw = 2'b00;
    if (rr) begin
      gnt_raw[1] = elig[1];
      gnt_raw[0] = elig[0] & ~elig[1];
    end else begin
      gnt_raw[0] = elig[0];
      gnt_raw[1] = elig[1] & ~elig[0];
    end
  end
`endif

  assign gnt = rst ? gnt_raw : 2'b00;
  assign any = |gnt;
  assign gid = gnt[1];
  assign gop = gid ? req_op[1] : req_op[0];

  assign psh     = any & gop;
  assign pop     = any & ~gop;
  assign do_push = psh & ~full;
  assign do_pop  = pop & ~empty;

  // Illegal requests are still granted so nobody deadlocks.
  assign req_ready = gnt;
  assign stk_push  = do_push;
  assign stk_pop   = do_pop;

  always_comb begin
    stk_in = '0;
    if (do_push) begin
      stk_in = gid ? req_data1 : req_data0;
    end
  end

  always_comb begin
    state_nx = IDLE;
    if (do_push) begin
      state_nx = SETTLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

`ifndef STACK_CTRL_FIXED_PRIO_EN
  // Pointer favours the loser of the last grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr <= 1'b0;
    end else if (any) begin
      rr <= ~gid;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
    end else if (do_push) begin
      level <= level + ONE;
    end else if (do_pop) begin
      level <= level - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_id    <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= do_pop;
      if (do_pop) begin
        rd_id   <= gid;
        rd_data <= stk_out;
      end
    end
  end

  // A fresh error in the clearing cycle wins over err_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      ovf_err <= (ovf_err & ~err_clr) | (psh & full);
      unf_err <= (unf_err & ~err_clr) | (pop & empty);
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed plus random stimulus against a queue model.
// Includes a behavioural stack that drives stk_out.
module tb_stack_ctrl;

  localparam int NADDR = 7;
  localparam int DEPTH = 4;
  localparam int NBITS = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_op = '0;
  logic [NBITS-1:0] req_data0 = '0;
  logic [NBITS-1:0] req_data1 = '0;
  logic [1:0]       req_ready;
  logic             stk_rst;
  logic             stk_push;
  logic             stk_pop;
  logic [NBITS-1:0] stk_in;
  logic [NBITS-1:0] stk_out;
  logic             rd_valid;
  logic             rd_id;
  logic [NBITS-1:0] rd_data;
  logic [NADDR-1:0] level;
  logic             full;
  logic             empty;
  logic             ovf_err;
  logic             unf_err;
  logic             err_clr = 1'b0;

  stack_ctrl #(
    .NADDR(NADDR),
    .DEPTH(DEPTH),
    .NBITS(NBITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_op(req_op),
    .req_data0(req_data0),
    .req_data1(req_data1),
    .req_ready(req_ready),
    .stk_rst(stk_rst),
    .stk_push(stk_push),
    .stk_pop(stk_pop),
    .stk_in(stk_in),
    .stk_out(stk_out),
    .rd_valid(rd_valid),
    .rd_id(rd_id),
    .rd_data(rd_data),
    .level(level),
    .full(full),
    .empty(empty),
    .ovf_err(ovf_err),
    .unf_err(unf_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Stack: a pop exposes the new top at once, a push shows up one
  // edge later.
  logic [NBITS-1:0] smem[$];
  always @(posedge clk or posedge stk_rst) begin
    if (stk_rst) begin
      smem.delete();
      stk_out <= '0;
    end else begin
      int t;
      t = smem.size();
      if (stk_pop && t > 0) begin
        stk_out <= (t >= 2) ? smem[t-2] : '0;
        void'(smem.pop_back());
      end else begin
        stk_out <= (t > 0) ? smem[t-1] : '0;
        if (stk_push) smem.push_back(stk_in);
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int m_q[$];
  bit m_settle;
  bit m_ptr;
  bit m_ovf;
  bit m_unf;
  int gq[$];
  int rdq[$];
  int npush;

  task automatic model_reset();
    m_q.delete();
    m_settle = 0;
    m_ptr = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic step(input logic [1:0] v, input logic [1:0] op,
                      input logic [NBITS-1:0] d0,
                      input logic [NBITS-1:0] d1, input logic clr);
    bit [1:0] el;
    int g;
    int sz;
    bit lpush, lpop, bpush, bpop;
    int dat, popped;
    @(negedge clk);
    req_valid = v;
    req_op = op;
    req_data0 = d0;
    req_data1 = d1;
    err_clr = clr;
    #1;
    for (int i = 0; i < 2; i++)
      el[i] = v[i] && !(m_settle && !op[i]);
    g = -1;
`ifdef STACK_CTRL_FIXED_PRIO_EN
    if (el[0]) g = 0;
    else if (el[1]) g = 1;
`else
    if (el[m_ptr]) g = int'(m_ptr);
    else if (el[!m_ptr]) g = int'(!m_ptr);
`endif
    sz = m_q.size();
    lpush = (g >= 0) && op[g] && sz < DEPTH;
    bpush = (g >= 0) && op[g] && sz == DEPTH;
    lpop = (g >= 0) && !op[g] && sz > 0;
    bpop = (g >= 0) && !op[g] && sz == 0;
    dat = (g == 1) ? int'(d1) : int'(d0);
    check("req_ready", 32'(req_ready), (g < 0) ? 0 : (1 << g));
    check("stk_push", 32'(stk_push), 32'(lpush));
    check("stk_pop", 32'(stk_pop), 32'(lpop));
    if (lpush) check("stk_in", 32'(stk_in), dat);
    if (stk_push) npush++;
    gq.push_back(g);
    @(posedge clk);
    #1;
    popped = 0;
    if (lpush) m_q.push_back(dat);
    if (lpop) popped = m_q.pop_back();
    m_ovf = (m_ovf && !clr) || bpush;
    m_unf = (m_unf && !clr) || bpop;
    m_settle = lpush;
    if (g >= 0) m_ptr = (g == 0);
    check("rd_valid", 32'(rd_valid), 32'(lpop));
    if (lpop) begin
      check("rd_id", 32'(rd_id), g);
      check("rd_data", 32'(rd_data), popped);
    end
    if (rd_valid) rdq.push_back(int'(rd_data));
    check("level", 32'(level), m_q.size());
    check("full", 32'(full), 32'(m_q.size() == DEPTH));
    check("empty", 32'(empty), 32'(m_q.size() == 0));
    check("ovf_err", 32'(ovf_err), 32'(m_ovf));
    check("unf_err", 32'(unf_err), 32'(m_unf));
  endtask

  task automatic idle();
    step(2'b00, 2'b00, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b11;
    req_op = 2'b00;
    #1;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_stk_rst", 32'(stk_rst), 1);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_rd_id", 32'(rd_id), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_errs", {30'd0, ovf_err, unf_err}, 0);
    check("rst_strobes", {30'd0, stk_push, stk_pop}, 0);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    npush = 0;
    do_reset();

    // Requester 1 pushes three values, then pops them back.
    npush = 0;
    step(2'b10, 2'b10, 8'h00, 8'h11, 1'b0);
    step(2'b10, 2'b10, 8'h00, 8'h22, 1'b0);
    step(2'b10, 2'b10, 8'h00, 8'h33, 1'b0);
    check("lifo_npush", npush, 3);
    check("lifo_level", 32'(level), 3);
    rdq.delete();
    for (int i = 0; i < 4; i++) step(2'b10, 2'b00, '0, '0, 1'b0);
    check("lifo_count", rdq.size(), 3);
    if (rdq.size() == 3) begin
      check("lifo_rd0", rdq[0], 32'h33);
      check("lifo_rd1", rdq[1], 32'h22);
      check("lifo_rd2", rdq[2], 32'h11);
    end
    check("lifo_empty", 32'(empty), 1);

    // Pop right after a push waits one cycle.
    step(2'b01, 2'b01, 8'hA5, '0, 1'b0);
    rdq.delete();
    step(2'b01, 2'b00, '0, '0, 1'b0);
    check("settle_hold", rdq.size(), 0);
    step(2'b01, 2'b00, '0, '0, 1'b0);
    check("settle_cnt", rdq.size(), 1);
    if (rdq.size() == 1) check("settle_data", rdq[0], 32'hA5);

    // Overflow, then clear.
    for (int i = 0; i < DEPTH; i++)
      step(2'b01, 2'b01, 8'(i + 1), '0, 1'b0);
    npush = 0;
    step(2'b01, 2'b01, 8'h77, '0, 1'b0);
    check("ovf_nopush", npush, 0);
    check("ovf_set", 32'(ovf_err), 1);
    check("ovf_level", 32'(level), DEPTH);
    step(2'b00, 2'b00, '0, '0, 1'b1);
    check("ovf_clr", 32'(ovf_err), 0);
    for (int i = 0; i < DEPTH + 1; i++) step(2'b01, 2'b00, '0, '0, 1'b0);

    // Underflow on the now-empty stack.
    step(2'b00, 2'b00, '0, '0, 1'b1);
    rdq.delete();
    step(2'b10, 2'b00, '0, '0, 1'b0);
    check("unf_set", 32'(unf_err), 1);
    check("unf_nord", rdq.size(), 0);
    step(2'b01, 2'b00, '0, '0, 1'b1);
    check("unf_sticky", 32'(unf_err), 1);
    idle();

    // Both push for four cycles.
    do_reset();
    gq.delete();
    for (int i = 0; i < 4; i++) step(2'b11, 2'b11, 8'(i), 8'(i + 8), 1'b0);
`ifdef STACK_CTRL_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) check("arb_fixed", gq[i], 0);
`else
    for (int i = 0; i < 4; i++) check("arb_rr", gq[i], i % 2);
`endif

    // Reset while pop data is being returned.
    idle();
    step(2'b01, 2'b00, '0, '0, 1'b0);
    check("mid_rd_valid", 32'(rd_valid), 1);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] v, op;
      v = 2'($urandom_range(0, 3));
      op = 2'($urandom_range(0, 3));
      step(v, op, 8'($urandom), 8'($urandom), $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
